// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_t : controller states (IDLE, CALC, DONE)
//   DIV_N       : default divisor/remainder width; dividend/quotient are 2*DIV_N
//   DIV_CNT_W   : default iteration counter width (2**DIV_CNT_W > 2*DIV_N)
//   DIV_ITER    : number of restoring iterations (one per quotient bit)
//   DIV0_QUOT / DIV0_REM : results reported when the divisor is zero
package div_pkg;

  localparam int DIV_N     = 8;
  localparam int DIV_CNT_W = 5;
  localparam int DIV_ITER  = 2 * DIV_N;

  localparam logic [2*DIV_N-1:0] DIV0_QUOT = '1;
  localparam logic [DIV_N-1:0]   DIV0_REM  = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   p      : current partial remainder (N+1 bits, never exceeds the divisor)
//   q_msb  : dividend bit shifted into the partial remainder this step
//   d      : divisor
//   p_next : partial remainder after the step
//   q_bit  : quotient bit produced by the step
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   p,
  input  logic         q_msb,
  input  logic [N-1:0] d,
  output logic [N:0]   p_next,
  output logic         q_bit
);

  logic [N:0]   shifted;
  logic [N+1:0] trial;

  assign shifted = {p[N-1:0], q_msb};
  // One extra bit above the shifted remainder acts as the borrow/sign flag.
  assign trial   = {1'b0, shifted} - {2'b00, d};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    p_next = shifted;
    q_bit  = 1'b0;
    if (!trial[N+1]) begin
      p_next = trial[N:0];
      q_bit  = 1'b1;
    end
  end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential restoring divider: 2N-bit unsigned dividend / N-bit unsigned
// divisor, one quotient bit per clock, valid/ready handshakes on both sides.
//   clk, rst               : rising-edge clock, async active-high reset
//   in_valid / in_ready    : operand handshake (accepted only in IDLE)
//   dividend, divisor      : operands, sampled on the input handshake only
//   out_valid / out_ready  : result handshake (held indefinitely in DONE)
//   quotient, remainder    : registered result; retained after the handshake
//   div_by_zero            : result came from a zero divisor (quotient all ones)
// The divide-by-zero constants come from div_pkg and are sized for N == DIV_N.
module div_16x8_seq
  import div_pkg::*;
#(
  parameter int N     = DIV_N,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * N - 1);

  div_state_t     state, state_d;
  logic [2*N-1:0] q, q_d;
  logic [N-1:0]   d, d_d;
  logic [N:0]     p, p_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic           dz, dz_d;
  logic           in_ready_d, out_valid_d, div_by_zero_d;
  logic [2*N-1:0] quotient_d;
  logic [N-1:0]   remainder_d;

  logic [N:0]     p_step;
  logic           q_bit;
  logic [2*N-1:0] q_shift;

  div_step #(.N(N)) u_step (
    .p      (p),
    .q_msb  (q[2*N-1]),
    .d      (d),
    .p_next (p_step),
    .q_bit  (q_bit)
  );

  assign q_shift = {q[2*N-2:0], q_bit};

  always_comb begin
    state_d       = state;
    q_d           = q;
    d_d           = d;
    p_d           = p;
    cnt_d         = cnt;
    dz_d          = dz;
    in_ready_d    = in_ready;
    out_valid_d   = out_valid;
    quotient_d    = quotient;
    remainder_d   = remainder;
    div_by_zero_d = div_by_zero;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          q_d        = dividend;
          d_d        = divisor;
          p_d        = '0;
          cnt_d      = '0;
          dz_d       = (divisor == '0);
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end

      CALC: begin
        q_d   = q_shift;
        p_d   = p_step;
        cnt_d = cnt + CNT_W'(1);
        // A zero divisor still runs all iterations so latency never depends on data.
        if (cnt == LAST_CNT) begin
          state_d       = DONE;
          out_valid_d   = 1'b1;
          div_by_zero_d = dz;
          if (dz) begin
            quotient_d  = DIV0_QUOT;
            remainder_d = DIV0_REM;
          end else begin
            quotient_d  = q_shift;
            remainder_d = p_step[N-1:0];
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      q           <= '0;
      d           <= '0;
      p           <= '0;
      cnt         <= '0;
      dz          <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_d;
      q           <= q_d;
      d           <= d_d;
      p           <= p_d;
      cnt         <= cnt_d;
      dz          <= dz_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= div_by_zero_d;
    end
  end

endmodule

// File: tb/tb_div_16x8_seq.sv
// Self-checking bench for div_16x8_seq: directed operations with literal
// expectations plus a continuous arithmetic model checked on every falling edge.
module tb_div_16x8_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int checks   = 0;
  int errors   = 0;
  int edge_cnt = 0;
  int done_cnt = 0;

  div_16x8_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain integer division, zero divisor reported as all-ones.
  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r,
                                output logic dz);
    if (b == 8'd0) begin
      q  = 16'hFFFF;
      r  = 8'd0;
      dz = 1'b1;
    end else begin
      q  = a / {8'd0, b};
      r  = 8'(a % {8'd0, b});
      dz = 1'b0;
    end
  endfunction

  // Transaction-level model: one operation in flight, result visible 16 edges
  // after the accepting edge, input side blocked until the result is taken.
  logic        m_busy = 1'b0;
  int          m_acc  = 0;
  logic [15:0] m_q;
  logic [7:0]  m_r;
  logic        m_dz;
  logic        exp_ov;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
    end else begin
      exp_ov = m_busy && ((edge_cnt - m_acc) >= 16);
      check("mdl_in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
      check("mdl_out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      if (exp_ov) begin
        check("mdl_quotient", {16'd0, quotient}, {16'd0, m_q});
        check("mdl_remainder", {24'd0, remainder}, {24'd0, m_r});
        check("mdl_div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dz});
      end
      if (!m_busy && in_valid) begin
        model(dividend, divisor, m_q, m_r, m_dz);
        m_busy = 1'b1;
        m_acc  = edge_cnt + 1;
      end else if (exp_ov && out_ready) begin
        m_busy   = 1'b0;
        done_cnt = done_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check({name, "_ready_timeout"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er, input logic edz,
                        input int stall);
    int acc;
    int n;
    logic [15:0] hold_q;
    wait_ready(name);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    acc      = edge_cnt;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 32'(edge_cnt - acc), 32'd16);
    check({name, "_quotient"}, {16'd0, quotient}, {16'd0, eq});
    check({name, "_remainder"}, {24'd0, remainder}, {24'd0, er});
    check({name, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
    hold_q = quotient;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      tick();
      check({name, "_stall_quotient"}, {16'd0, quotient}, {16'd0, eq});
      check({name, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_post_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
    if (stall > 0) check({name, "_retained"}, {16'd0, quotient}, {16'd0, hold_q});
  endtask

  initial begin
    logic [15:0] mq;
    logic [7:0]  mr;
    logic        mdz;
    int          acc_a;
    int          acc_b;
    int          n;
    logic        got_a;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    tick();

    // Pin the reference model against hand-computed results.
    model(16'hB3B0, 8'hE6, mq, mr, mdz);
    check("model_pin_q", {16'd0, mq}, 32'h00C8);
    model(16'h03E8, 8'h07, mq, mr, mdz);
    check("model_pin_r", {24'd0, mr}, 32'h06);
    model(16'h1234, 8'h00, mq, mr, mdz);
    check("model_pin_dz", {15'd0, mdz, mq}, 32'h1FFFF);

    run_op("exact",     16'hB3B0, 8'hE6, 16'h00C8, 8'h00, 1'b0, 0);
    run_op("rem",       16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 0);
    run_op("div_one",   16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 0);
    run_op("div_zero",  16'h1234, 8'h00, 16'hFFFF, 8'h00, 1'b1, 0);
    run_op("zero_num",  16'h0000, 8'h33, 16'h0000, 8'h00, 1'b0, 0);
    run_op("backpress", 16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0, 5);

    // Reset during iteration 7: everything must clear without waiting for a clock.
    wait_ready("midrst");
    in_valid = 1'b1;
    dividend = 16'h1234;
    divisor  = 8'h56;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_quotient", {16'd0, quotient}, 32'd0);
    check("midrst_remainder", {24'd0, remainder}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op("after_rst", 16'h00FF, 8'h10, 16'h000F, 8'h0F, 1'b0, 0);

    // Back-to-back with the consumer always ready.
    out_ready = 1'b1;
    wait_ready("b2b");
    in_valid = 1'b1;
    dividend = 16'h8000;
    divisor  = 8'h80;
    tick();
    acc_a    = edge_cnt;
    dividend = 16'h0005;
    divisor  = 8'h09;
    got_a    = 1'b0;
    n        = 0;
    while (!in_ready && n < 40) begin
      if (out_valid) begin
        got_a = 1'b1;
        check("b2b_a_quotient", {16'd0, quotient}, 32'h0100);
        check("b2b_a_remainder", {24'd0, remainder}, 32'h00);
      end
      tick();
      n++;
    end
    check("b2b_a_seen", {31'd0, got_a}, 32'd1);
    tick();
    acc_b    = edge_cnt;
    in_valid = 1'b0;
    check("b2b_spacing", 32'(acc_b - acc_a), 32'd18);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("b2b_b_latency", 32'(edge_cnt - acc_b), 32'd16);
    check("b2b_b_quotient", {16'd0, quotient}, 32'h0000);
    check("b2b_b_remainder", {24'd0, remainder}, 32'h05);
    tick();
    out_ready = 1'b0;
    check("b2b_done_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    check("completed_ops", 32'(done_cnt), 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
